// File: rtl/io_out_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : io_out_arbiter
//  Purpose  : Round-robin sharing of one WIDTH-bit output bus between NREQ
//             sources. A granted word is latched, held for DWELL cycles,
//             then the owner gets a one-cycle ack pulse. IDLE is always
//             visited for one cycle between grants.
//  Options  : IO_OUT_ARB_IDLE_CNT_EN - when defined, the bus shows a
//             free-running counter while idle instead of all zeros.
//  Revision : 1.0 - initial release
// ============================================================================
module io_out_arbiter #(
    parameter int NREQ  = 4,   // number of requesters, 2..8
    parameter int WIDTH = 8,   // bus and per-requester word width
    parameter int DWELL = 8    // cycles a granted word is held, >= 1
) (
    input  logic                    clk,
    input  logic                    rst,       // asynchronous, active-low
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   data,
    output logic [NREQ-1:0]         ack,
    output logic [WIDTH-1:0]        out,
    output logic                    busy,
    output logic [2:0]              grant_id
);

    // ------------------------------------------------------------------------
    // Local constants
    // ------------------------------------------------------------------------
    // Dwell counter only needs to reach DWELL-1; keep at least one bit so a
    // DWELL of 1 still yields a legal vector.
    localparam int               CNT_W    = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [2:0]       LAST_ID  = 3'(NREQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_ACK   = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t              state_q;
    logic [2:0]          ptr_q;        // round-robin start index
    logic [CNT_W-1:0]    cnt_q;        // remaining dwell cycles minus one
    logic [WIDTH-1:0]    out_q;
    logic [NREQ-1:0]     ack_q;
    logic                busy_q;
    logic [2:0]          grant_id_q;

    // Arbitration result and helpers
    logic                pick_vld;
    logic [2:0]          pick_idx;
    logic [WIDTH-1:0]    pick_word;
    logic [NREQ-1:0]     ack_onehot;
    logic [2:0]          ptr_d;

    // Bus value to show while idle: value after this edge (staying idle)
    // and value to restore when coming back from ACK.
    logic [WIDTH-1:0]    idle_next;
    logic [WIDTH-1:0]    idle_hold;

    // ------------------------------------------------------------------------
    // Round-robin pick: first requester at or above the pointer, wrapping.
    // Scanning from the far end down lets the closest match win last.
    // ------------------------------------------------------------------------
    always_comb begin
        int j;
        j        = 0;
        pick_vld = 1'b0;
        pick_idx = 3'd0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = (int'(ptr_q) + k) % NREQ;
            if (req[j]) begin
                pick_vld = 1'b1;
                pick_idx = 3'(j);
            end
        end
    end

    // Select the winner's word from the packed data bus
    always_comb begin
        pick_word = data[int'(pick_idx)*WIDTH +: WIDTH];
    end

    // One-hot ack for the current owner and the pointer after its release
    always_comb begin
        ack_onehot = '0;
        for (int i = 0; i < NREQ; i++) begin
            ack_onehot[i] = (grant_id_q == 3'(i));
        end
        ptr_d = (grant_id_q == LAST_ID) ? 3'd0 : (grant_id_q + 3'd1);
    end

    // ------------------------------------------------------------------------
    // Idle display value
    // ------------------------------------------------------------------------
`ifdef IO_OUT_ARB_IDLE_CNT_EN
    localparam logic [WIDTH-1:0] W_ONE = WIDTH'(1);

    logic [WIDTH-1:0] idle_cnt_q;

    // Free-running counter that only advances on edges spent in IDLE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idle_cnt_q <= '0;
        end else if (state_q == ST_IDLE) begin
            idle_cnt_q <= idle_cnt_q + W_ONE;
        end
    end

    assign idle_next = idle_cnt_q + W_ONE;
    assign idle_hold = idle_cnt_q;
`else
    assign idle_next = '0;
    assign idle_hold = '0;
`endif

    // ------------------------------------------------------------------------
    // Arbiter FSM with registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            ptr_q      <= 3'd0;
            cnt_q      <= '0;
            out_q      <= '0;
            ack_q      <= '0;
            busy_q     <= 1'b0;
            grant_id_q <= 3'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pick_vld) begin
                        // Latch the word now; later data changes are ignored
                        out_q      <= pick_word;
                        grant_id_q <= pick_idx;
                        busy_q     <= 1'b1;
                        cnt_q      <= CNT_INIT;
                        state_q    <= ST_GRANT;
                    end else begin
                        out_q      <= idle_next;
                    end
                end

                ST_GRANT: begin
                    // Dwell runs to completion even if req drops meanwhile
                    if (cnt_q == '0) begin
                        ack_q   <= ack_onehot;
                        state_q <= ST_ACK;
                    end else begin
                        cnt_q   <= cnt_q - CNT_ONE;
                    end
                end

                ST_ACK: begin
                    ack_q   <= '0;
                    busy_q  <= 1'b0;
                    ptr_q   <= ptr_d;
                    out_q   <= idle_hold;
                    state_q <= ST_IDLE;
                end

                default: begin
                    ack_q   <= '0;
                    busy_q  <= 1'b0;
                    out_q   <= '0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign out      = out_q;
    assign ack      = ack_q;
    assign busy     = busy_q;
    assign grant_id = grant_id_q;

endmodule
`default_nettype wire

// File: tb/tb_io_out_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_io_out_arbiter
//  Purpose  : Self-checking bench for io_out_arbiter. A schedule-based model
//             turns each grant decision into the list of bus/ack/busy values
//             expected over the following cycles.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_io_out_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int DWELL = 8;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic [NREQ-1:0]       req = '0;
    logic [NREQ*WIDTH-1:0] data = '0;
    logic [NREQ-1:0]       dut_ack;
    logic [WIDTH-1:0]      dut_out;
    logic                  dut_busy;
    logic [2:0]            dut_gid;

    io_out_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .DWELL(DWELL)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .data     (data),
        .ack      (dut_ack),
        .out      (dut_out),
        .busy     (dut_busy),
        .grant_id (dut_gid)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Reference model: one entry per future cycle
    // ------------------------------------------------------------------------
    typedef struct {
        logic [WIDTH-1:0] word;
        logic [NREQ-1:0]  ackv;
        logic             bsy;
        logic [2:0]       gid;
        bit               idle;   // bus shows the idle value
    } ent_t;

    ent_t             sched[$];
    int               m_ptr;
    logic [2:0]       m_gid;
    logic [WIDTH-1:0] m_cnt;

    logic [WIDTH-1:0] exp_out;
    logic [NREQ-1:0]  exp_ack;
    logic             exp_busy;
    logic [2:0]       exp_gid;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs === expv) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, expv, $time);
    endtask

    task automatic model_reset();
        sched.delete();
        m_ptr = 0;
        m_gid = 3'd0;
        m_cnt = '0;
    endtask

    // Predict the outputs after the coming clock edge from current inputs
    task automatic model_step();
        ent_t e;
        int   w;
        if (sched.size() == 0) begin
            m_cnt = m_cnt + 1'b1;       // only relevant with the idle counter
            if (req != '0) begin
                w = -1;
                for (int k = 0; k < NREQ; k++)
                    if (w < 0 && req[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
                e.word = data[w*WIDTH +: WIDTH];
                e.gid  = 3'(w);
                e.bsy  = 1'b1;
                e.idle = 1'b0;
                e.ackv = '0;
                for (int k = 0; k < DWELL; k++) sched.push_back(e);
                e.ackv = NREQ'(1) << w;
                sched.push_back(e);
                e.ackv = '0;
                e.bsy  = 1'b0;
                e.idle = 1'b1;
                sched.push_back(e);
                m_ptr = (w + 1) % NREQ;
                m_gid = 3'(w);
            end else begin
                e.word = '0; e.ackv = '0; e.bsy = 1'b0; e.gid = m_gid; e.idle = 1'b1;
                sched.push_back(e);
            end
        end
        e = sched.pop_front();
`ifdef IO_OUT_ARB_IDLE_CNT_EN
        exp_out = e.idle ? m_cnt : e.word;
`else
        exp_out = e.idle ? '0 : e.word;
`endif
        exp_ack  = e.ackv;
        exp_busy = e.bsy;
        exp_gid  = e.gid;
    endtask

    // One clock: predict, clock, compare, then release requesters just acked
    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        chk("out",      dut_out,  exp_out);
        chk("ack",      dut_ack,  exp_ack);
        chk("busy",     dut_busy, exp_busy);
        chk("grant_id", dut_gid,  exp_gid);
        for (int i = 0; i < NREQ; i++) if (exp_ack[i]) req[i] = 1'b0;
    endtask

    task automatic run_until_idle();
        int guard;
        guard = 0;
        while (sched.size() != 0 && guard < 4 * DWELL) begin
            cycle();
            guard++;
        end
    endtask

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        int acks;
        int guard;
        int low_cnt [NREQ];
        int rr_exp  [5];
        int r;

        rr_exp[0] = 0; rr_exp[1] = 1; rr_exp[2] = 2; rr_exp[3] = 3; rr_exp[4] = 0;
        model_reset();

        // Reset state while held in reset
        #12;
        chk("rst_out",  dut_out,  0);
        chk("rst_ack",  dut_ack,  0);
        chk("rst_busy", dut_busy, 0);
        chk("rst_gid",  dut_gid,  0);
        @(posedge clk); #1;
        rst = 1'b1;

        // Idle after reset: bus shows idle value
        for (int i = 0; i < 5; i++) cycle();

        // Round-robin with everyone requesting, re-raising after a gap
        req  = 4'b1111;
        data = {8'h44, 8'h33, 8'h22, 8'h11};
        for (int i = 0; i < NREQ; i++) low_cnt[i] = 0;
        acks  = 0;
        guard = 0;
        while (acks < 5 && guard < 200) begin
            cycle();
            if (exp_ack != '0) begin
                chk("rr_order", dut_gid, rr_exp[acks]);
                acks++;
            end
            for (int i = 0; i < NREQ; i++) begin
                if (!req[i]) begin
                    low_cnt[i]++;
                    if (low_cnt[i] >= 2 && acks < 4) begin req[i] = 1'b1; low_cnt[i] = 0; end
                end
            end
            guard++;
        end
        chk("rr_grants", acks, 5);
        req = '0;
        run_until_idle();
        cycle();

        // Single grant of requester 2
        data[2*WIDTH +: WIDTH] = 8'h3C;
        req = 4'b0100;
        cycle();
        chk("single_out", dut_out, 8'h3C);
        run_until_idle();

        // Data latch: word changes during GRANT must not reach the bus
        data[0 +: WIDTH] = 8'h11;
        req = 4'b0001;
        for (int i = 0; i < 3; i++) cycle();
        data[0 +: WIDTH] = 8'h22;
        cycle();
        chk("latch_out", dut_out, 8'h11);
        run_until_idle();

        // Early drop: requester 3 lets go two cycles into GRANT
        data[3*WIDTH +: WIDTH] = 8'h5A;
        req = 4'b1000;
        cycle();
        cycle();
        cycle();
        req[3] = 1'b0;
        run_until_idle();

        // Asynchronous reset in the middle of a grant
        data[1*WIDTH +: WIDTH] = 8'hA5;
        req = 4'b0010;
        for (int i = 0; i < 4; i++) cycle();
        chk("pre_rst_busy", dut_busy, 1);
        #2 rst = 1'b0;
        #1;
        chk("arst_out",  dut_out,  0);
        chk("arst_busy", dut_busy, 0);
        chk("arst_ack",  dut_ack,  0);
        chk("arst_gid",  dut_gid,  0);
        model_reset();
        req = 4'b0011;
        @(posedge clk); #1;
        rst = 1'b1;
        cycle();
        chk("post_rst_gid", dut_gid, 0);
        run_until_idle();

        // Randomised traffic
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                r = int'($urandom_range(0, 31));
                if (!req[i] && r < 6) begin
                    req[i] = 1'b1;
                    data[i*WIDTH +: WIDTH] = 8'($urandom);
                end else if (req[i] && r == 31) begin
                    req[i] = 1'b0;                              // early drop
                end else if (r == 30) begin
                    data[i*WIDTH +: WIDTH] = 8'($urandom);      // data wiggle
                end
            end
            cycle();
            // occasionally keep requesting right through the ack
            if (exp_ack != '0 && $urandom_range(0, 7) == 0) req = req | exp_ack;
        end
        req = '0;
        run_until_idle();
        cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
